// File: rtl/lookup_export_bank.sv
// lookup_export_bank: double-buffered lookup table with an Avalon-MM shadow bank,
// a commit/clear control word and a flat export bus driven by the active bank.
module lookup_export_bank #(
  parameter int unsigned N_WORDS   = 258,
  parameter int unsigned DATA_W    = 32,
  parameter bit          IMMEDIATE = 1'b0,
  parameter int unsigned ADDR_W    = $clog2(N_WORDS + 2)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           avs_address,
  input  logic                        avs_write,
  input  logic [DATA_W-1:0]           avs_writedata,
  input  logic [DATA_W/8-1:0]         avs_byteenable,
  input  logic                        avs_read,
  output logic [DATA_W-1:0]           avs_readdata,
  input  logic                        frame_sync,
  output logic [N_WORDS*DATA_W-1:0]   export_data,
  output logic                        commit_pending,
  output logic [15:0]                 commit_count
);

  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned STAT_W      = 32;
  localparam int unsigned CTRL_ADDR   = N_WORDS;
  localparam int unsigned STATUS_ADDR = N_WORDS + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                swap_c;
  logic                ctrl_wr_c;
  logic                commit_req_c;
  logic                clear_req_c;
  logic                entry_wr_c;
  logic [STAT_W-1:0]   status_c;
  logic [DATA_W-1:0]   rd_mux_c;
  logic [DATA_W-1:0]   shadow_q [N_WORDS];

  // Decode of control-word and shadow-entry writes
  assign ctrl_wr_c    = avs_write && (avs_address == ADDR_W'(CTRL_ADDR));
  assign commit_req_c = ctrl_wr_c && avs_writedata[0];
  assign clear_req_c  = ctrl_wr_c && avs_writedata[1];
  assign entry_wr_c   = avs_write && (avs_address < ADDR_W'(N_WORDS));
  assign status_c     = {commit_count, 15'd0, commit_pending};

  // Commit state register; commit_pending mirrors the next state so it is a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      commit_pending <= 1'b0;
    end else begin
      state_q        <= state_d;
      commit_pending <= (state_d == PENDING);
    end
  end

  // Next-state logic; a commit seen while pending is absorbed by the pending swap
  always_comb begin
    state_d = state_q;
    swap_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req_c) state_d = PENDING;
      end
      PENDING: begin
        if (IMMEDIATE || frame_sync) begin
          swap_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow bank: CLEAR zeroes every entry, otherwise byte-lane writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WORDS; i++) begin
      if (reset || clear_req_c) begin
        shadow_q[i] <= '0;
      end else if (entry_wr_c && (avs_address == ADDR_W'(i))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (avs_byteenable[b]) shadow_q[i][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

  // Active bank: whole shadow copied in the swap cycle using pre-write shadow values
  always_ff @(posedge clk) begin
    if (reset) begin
      export_data <= '0;
    end else if (swap_c) begin
      for (int i = 0; i < N_WORDS; i++) begin
        export_data[i*DATA_W +: DATA_W] <= shadow_q[i];
      end
    end
  end

  // Completed-copy counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_count <= '0;
    end else if (swap_c) begin
      commit_count <= commit_count + 16'd1;
    end
  end

  // Read mux: shadow entries, status word, zero elsewhere (CTRL reads as 0)
  always_comb begin
    rd_mux_c = '0;
    if (avs_address == ADDR_W'(STATUS_ADDR)) rd_mux_c = DATA_W'(status_c);
    for (int i = 0; i < N_WORDS; i++) begin
      if (avs_address == ADDR_W'(i)) rd_mux_c = shadow_q[i];
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_lookup_export_bank.sv
// Testbench for lookup_export_bank: directed steps plus randomized traffic on a
// frame-synced instance checked against an array model, and directed checks on
// a small immediate-mode instance.
module tb_lookup_export_bank;

  localparam int unsigned N0 = 258;
  localparam int unsigned A0 = 9;
  localparam int unsigned N1 = 4;
  localparam int unsigned A1 = 3;
  localparam int unsigned W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // frame-synced instance
  logic [A0-1:0]   a0_addr = '0;
  logic            a0_wr   = 1'b0;
  logic [W-1:0]    a0_wd   = '0;
  logic [3:0]      a0_be   = '0;
  logic            a0_rd   = 1'b0;
  logic [W-1:0]    a0_rdata;
  logic            fs0     = 1'b0;
  logic [N0*W-1:0] ex0;
  logic            pend0;
  logic [15:0]     cnt0;

  // immediate instance
  logic [A1-1:0]   a1_addr = '0;
  logic            a1_wr   = 1'b0;
  logic [W-1:0]    a1_wd   = '0;
  logic [3:0]      a1_be   = '0;
  logic            a1_rd   = 1'b0;
  logic [W-1:0]    a1_rdata;
  logic            fs1     = 1'b0;
  logic [N1*W-1:0] ex1;
  logic            pend1;
  logic [15:0]     cnt1;

  lookup_export_bank #(.N_WORDS(N0), .DATA_W(W), .IMMEDIATE(1'b0)) dut0 (
    .clk(clk), .reset(rst),
    .avs_address(a0_addr), .avs_write(a0_wr), .avs_writedata(a0_wd),
    .avs_byteenable(a0_be), .avs_read(a0_rd), .avs_readdata(a0_rdata),
    .frame_sync(fs0), .export_data(ex0), .commit_pending(pend0), .commit_count(cnt0)
  );

  lookup_export_bank #(.N_WORDS(N1), .DATA_W(W), .IMMEDIATE(1'b1)) dut1 (
    .clk(clk), .reset(rst),
    .avs_address(a1_addr), .avs_write(a1_wr), .avs_writedata(a1_wd),
    .avs_byteenable(a1_be), .avs_read(a1_rd), .avs_readdata(a1_rdata),
    .frame_sync(fs1), .export_data(ex1), .commit_pending(pend1), .commit_count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of dut0
  logic [W-1:0] sh_m [N0];
  logic [W-1:0] ac_m [N0];
  logic         pend_m;
  logic [15:0]  cnt_m;
  logic [W-1:0] rd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_export();
    logic [N0*W-1:0] e;
    int k;
    for (int i = 0; i < N0; i++) e[i*W +: W] = ac_m[i];
    n_cmp++;
    assert (ex0 === e) else begin
      n_bad++;
      k = 0;
      for (int i = N0 - 1; i >= 0; i--) if (ex0[i*W +: W] !== e[i*W +: W]) k = i;
      $error("FAIL export word %0d: got %h expected %h", k, ex0[k*W +: W], e[k*W +: W]);
    end
  endtask

  // One clock of architectural behaviour, evaluated from the inputs about to be sampled
  task automatic model_step();
    int  ai;
    bit  was_pending;
    ai = int'(a0_addr);
    if (rst) begin
      for (int i = 0; i < N0; i++) begin
        sh_m[i] = '0;
        ac_m[i] = '0;
      end
      pend_m = 1'b0;
      cnt_m  = '0;
      rd_m   = '0;
      return;
    end
    if (a0_rd) begin
      if (ai < N0)          rd_m = sh_m[ai];
      else if (ai == N0 + 1) rd_m = {cnt_m, 15'd0, pend_m};
      else                  rd_m = '0;
    end
    was_pending = pend_m;
    if (pend_m && fs0) begin
      ac_m   = sh_m;
      cnt_m  = cnt_m + 16'd1;
      pend_m = 1'b0;
    end
    if (a0_wr) begin
      if (ai < N0) begin
        for (int b = 0; b < 4; b++) if (a0_be[b]) sh_m[ai][b*8 +: 8] = a0_wd[b*8 +: 8];
      end else if (ai == N0) begin
        if (a0_wd[1]) for (int i = 0; i < N0; i++) sh_m[i] = '0;
        if (a0_wd[0] && !was_pending) pend_m = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rdata", a0_rdata, rd_m);
    chk("pending", 32'(pend0), 32'(pend_m));
    chk("count", 32'(cnt0), 32'(cnt_m));
    chk_export();
    a0_wr = 1'b0;
    a0_rd = 1'b0;
    fs0   = 1'b0;
  endtask

  task automatic wr0(input int addr, input logic [31:0] data, input logic [3:0] be, input logic fs);
    a0_addr = A0'(addr);
    a0_wd   = data;
    a0_be   = be;
    a0_wr   = 1'b1;
    fs0     = fs;
    tick();
  endtask

  task automatic rd0(input int addr);
    a0_addr = A0'(addr);
    a0_rd   = 1'b1;
    tick();
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
    a1_wr = 1'b0;
    a1_rd = 1'b0;
    fs1   = 1'b0;
  endtask

  task automatic wr1(input int addr, input logic [31:0] data);
    a1_addr = A1'(addr);
    a1_wd   = data;
    a1_be   = 4'hF;
    a1_wr   = 1'b1;
    tick1();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int sel;
    int ai;
    logic [31:0] v1 [N1];

    // reset: everything reads as zero
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_pend1", 32'(pend1), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    for (int a = 0; a < 512; a++) rd0(a);

    // byte-lane merge
    wr0(5, 32'h11223344, 4'hF, 1'b0);
    wr0(5, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd0(5);
    chk("t2_read5", a0_rdata, 32'h11BB33DD);
    chk("t2_active5", ex0[5*W +: W], 32'h0);

    // commit waits for frame_sync
    wr0(N0, 32'h1, 4'hF, 1'b0);
    repeat (10) tick();
    chk("t3_pending", 32'(pend0), 32'd1);
    chk("t3_active5_hold", ex0[5*W +: W], 32'h0);
    fs0 = 1'b1;
    tick();
    chk("t3_active5", ex0[5*W +: W], 32'h11BB33DD);
    chk("t3_count", 32'(cnt0), 32'd1);
    chk("t3_pending_clr", 32'(pend0), 32'd0);

    // commit coincident with frame_sync does not swap
    wr0(5, 32'hCAFEF00D, 4'hF, 1'b0);
    wr0(N0, 32'h1, 4'hF, 1'b1);
    chk("t4_pending", 32'(pend0), 32'd1);
    chk("t4_no_swap", ex0[5*W +: W], 32'h11BB33DD);
    tick();
    fs0 = 1'b1;
    tick();
    chk("t4_swap", ex0[5*W +: W], 32'hCAFEF00D);
    chk("t4_count", 32'(cnt0), 32'd2);

    // shadow write during the swap cycle
    wr0(0, 32'h55, 4'hF, 1'b0);
    wr0(N0, 32'h1, 4'hF, 1'b0);
    wr0(0, 32'h1, 4'hF, 1'b1);
    chk("t5_active0_old", ex0[0 +: W], 32'h55);
    rd0(0);
    chk("t5_shadow0_new", a0_rdata, 32'h1);

    // clear+commit gives an all-zero active bank
    wr0(N0, 32'h3, 4'hF, 1'b0);
    rd0(N0 + 1);
    chk("status_pending", a0_rdata, 32'h0003_0001);
    fs0 = 1'b1;
    tick();
    chk("clr_active5", ex0[5*W +: W], 32'h0);
    chk("clr_count", 32'(cnt0), 32'd4);

    // second commit while pending, then frame_sync while idle
    wr0(7, 32'h0BADBEEF, 4'hF, 1'b0);
    wr0(N0, 32'h1, 4'hF, 1'b0);
    wr0(N0, 32'h1, 4'hF, 1'b0);
    fs0 = 1'b1;
    tick();
    fs0 = 1'b1;
    tick();
    chk("double_commit_count", 32'(cnt0), 32'd5);

    // read and write same address in one cycle returns the old value
    a0_rd = 1'b1;
    wr0(7, 32'h12345678, 4'hF, 1'b0);
    chk("rw_same_old", a0_rdata, 32'h0BADBEEF);
    rd0(N0);
    chk("ctrl_reads_zero", a0_rdata, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) begin
        ai = int'($urandom_range(0, 15));
        if (ai >= 8) ai = ai + 242;
      end else if (sel == 6) ai = N0;
      else if (sel == 7) ai = N0 + 1;
      else if (sel == 8) ai = int'($urandom_range(N0 + 2, 511));
      else ai = int'($urandom_range(0, N0 - 1));
      a0_addr = A0'(ai);
      a0_wr   = 1'($urandom_range(0, 1));
      a0_rd   = 1'($urandom_range(0, 1));
      a0_be   = 4'($urandom_range(0, 15));
      a0_wd   = $urandom;
      if (ai == N0) a0_wd = {30'd0, ($urandom_range(0, 7) == 0), 1'b1};
      fs0     = ($urandom_range(0, 5) == 0);
      tick();
    end

    // reset while pending discards the commit
    wr0(3, 32'hFEEDFACE, 4'hF, 1'b0);
    wr0(N0, 32'h1, 4'hF, 1'b0);
    fs0 = 1'b1;
    tick();
    wr0(N0, 32'h1, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_pending", 32'(pend0), 32'd0);
    chk("rstp_active3", ex0[3*W +: W], 32'h0);
    fs0 = 1'b1;
    tick();
    rd0(3);
    chk("rstp_shadow3", a0_rdata, 32'h0);

    // immediate-mode instance
    for (int i = 0; i < N1; i++) begin
      v1[i] = $urandom;
      wr1(i, v1[i]);
    end
    fs1 = 1'b1;
    tick1();
    chk("im_fs_idle_count", 32'(cnt1), 32'd0);
    chk("im_fs_idle_pend", 32'(pend1), 32'd0);
    wr1(N1, 32'h1);
    chk("im_pend", 32'(pend1), 32'd1);
    chk("im_hold0", ex1[0 +: W], 32'h0);
    tick1();
    chk("im_pend_clr", 32'(pend1), 32'd0);
    chk("im_count1", 32'(cnt1), 32'd1);
    for (int i = 0; i < N1; i++) chk("im_word", ex1[i*W +: W], v1[i]);
    wr1(N1, 32'h3);
    tick1();
    for (int i = 0; i < N1; i++) chk("im_clear_word", ex1[i*W +: W], 32'h0);
    chk("im_count2", 32'(cnt1), 32'd2);
    a1_addr = A1'(2);
    a1_rd   = 1'b1;
    tick1();
    chk("im_shadow_clr", a1_rdata, 32'h0);
    a1_addr = A1'(N1 + 1);
    a1_rd   = 1'b1;
    tick1();
    chk("im_status", a1_rdata, 32'h0002_0000);
    for (int k = 0; k < 10; k++) begin
      wr1(N1, 32'h1);
      tick1();
    end
    chk("im_count12", 32'(cnt1), 32'd12);
    wr1(N1, 32'h1);
    wr1(N1, 32'h1);
    tick1();
    chk("im_commit_in_swap", 32'(cnt1), 32'd13);
    chk("im_commit_in_swap_pend", 32'(pend1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
